// File: rtl/latch_bank_if.sv
// latch_bank_if: request/acknowledge bundle between two write requesters
// (master side) and latch_bank_ctrl (slave side).
interface latch_bank_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [WIDTH-1:0]  data0;
    logic [WIDTH-1:0]  data1;
    logic              ack0;
    logic              ack1;
    logic              err;
    logic              busy;

    modport master (
        output req0, req1, addr0, addr1, data0, data1,
        input  ack0, ack1, err, busy
    );

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1,
        output ack0, ack1, err, busy
    );
endinterface

// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: two-port arbiter and write sequencer for a bank of DEPTH
// level-sensitive latches. Every write runs SETUP -> OPEN -> HOLD so the shared
// data bus is stable a full clock before and after the single gate pulse.
// Optional macro LBC_ROUND_ROBIN_EN selects round-robin arbitration; without it
// requester 0 has fixed priority. DEPTH must not exceed 2**ADDR_W.
module latch_bank_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    latch_bank_if.slave      bus,
    output logic [WIDTH-1:0] lat_d,
    output logic [DEPTH-1:0] lat_g
);
    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

    // Extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic              grant;
    logic              win_sel;    // 0: requester 0 wins, 1: requester 1 wins
    logic              win_q;      // requester owning the write in flight
    logic [ADDR_W-1:0] addr_q;     // target entry of the write in flight
    logic              addr_bad;

    logic [WIDTH-1:0]  lat_d_q, lat_d_d;
    logic [DEPTH-1:0]  lat_g_q, lat_g_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    // Requests are only looked at in IDLE; anything arriving while busy waits.
    assign grant    = (state_q == IDLE) && (bus.req0 || bus.req1);
    assign addr_bad = ({1'b0, addr_q} >= DEPTH_LIM);

`ifdef LBC_ROUND_ROBIN_EN
    logic ptr_q;  // last requester served

    // Tie goes to the requester not served last; a lone requester always wins
    always_comb begin
        if (bus.req0 && bus.req1) win_sel = ~ptr_q;
        else                      win_sel = bus.req1;
    end

    // Pointer follows each grant; resetting to 1 hands requester 0 the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ptr_q <= 1'b1;
        else if (grant) ptr_q <= win_sel;
    end
`else
    // Fixed priority: requester 0 wins whenever it is asking.
    assign win_sel = ~bus.req0;
`endif

    // Commit the winner's identity and address at grant for the whole write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= 1'b0;
            addr_q <= '0;
        end else if (grant) begin
            win_q  <= win_sel;
            addr_q <= win_sel ? bus.addr1 : bus.addr0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: fixed four-phase write sequence
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = SETUP;
            SETUP:   state_d = OPEN;
            OPEN:    state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, keyed on the state being entered
    always_comb begin
        lat_d_d = lat_d_q;
        lat_g_d = '0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = (state_d != IDLE);

        // Data bus only moves on entry to SETUP, when every gate is already low.
        if (grant) lat_d_d = win_sel ? bus.data1 : bus.data0;

        // Out-of-range addresses match no entry, so the gate stays closed.
        if (state_d == OPEN) begin
            for (int i = 0; i < DEPTH; i++) lat_g_d[i] = (addr_q == ADDR_W'(i));
        end

        if (state_d == HOLD) begin
            ack0_d = ~win_q;
            ack1_d = win_q;
            err_d  = addr_bad;
        end
    end

    // Output registers; reset closes every gate immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_d_q <= '0;
            lat_g_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            lat_d_q <= lat_d_d;
            lat_g_q <= lat_g_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign lat_d    = lat_d_q;
    assign lat_g    = lat_g_q;
    assign bus.ack0 = ack0_q;
    assign bus.ack1 = ack1_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb_latch_bank_ctrl: scoreboard bench. A transaction-level model predicts each
// grant from request levels and cycle arithmetic; a negedge monitor compares
// the DUT outputs against the expected write at the head of the queue.
module tb_latch_bank_ctrl;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    typedef struct {
        int                who;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
        int                grant_cyc;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    latch_bank_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();
    latch_bank_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus3 ();
    logic [WIDTH-1:0] lat_d;
    logic [DEPTH-1:0] lat_g;
    logic [WIDTH-1:0] lat_d3;
    logic [2:0]       lat_g3;

    latch_bank_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .lat_d(lat_d), .lat_g(lat_g)
    );

    latch_bank_ctrl #(.WIDTH(WIDTH), .DEPTH(3), .ADDR_W(ADDR_W)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .lat_d(lat_d3), .lat_g(lat_g3)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    txn_t exp_q[$];
    int   cyc         = 0;
    int   next_free   = 0;     // earliest edge at which a new grant may happen
    int   last_grant  = -100;
    int   last_served = 1;     // so requester 0 wins the first tie
    int   m_who;
    txn_t m_t;

    // A write occupies four edges; a grant needs a free controller and a request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            next_free   = 0;
            last_grant  = -100;
            last_served = 1;
        end else begin
            cyc++;
            if (cyc >= next_free && (bus.req0 || bus.req1)) begin
`ifdef LBC_ROUND_ROBIN_EN
                if (bus.req0 && bus.req1) m_who = 1 - last_served;
                else                      m_who = bus.req0 ? 0 : 1;
`else
                m_who = bus.req0 ? 0 : 1;
`endif
                m_t.who       = m_who;
                m_t.addr      = (m_who == 1) ? bus.addr1 : bus.addr0;
                m_t.data      = (m_who == 1) ? bus.data1 : bus.data0;
                m_t.grant_cyc = cyc;
                exp_q.push_back(m_t);
                next_free   = cyc + 4;
                last_grant  = cyc;
                last_served = m_who;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [WIDTH-1:0] prev_d = '0;
    logic [DEPTH-1:0] prev_g = '0;
    txn_t             mon_t;
    int               mon_k;
    logic [DEPTH-1:0] mon_g;

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(bus.busy), 32'((cyc - last_grant) <= 2));
            check("gate_onehot", 32'($countones(lat_g) <= 1), 32'd1);
            if (lat_g != '0 || prev_g != '0) check("lat_d_stable_gate", 32'(lat_d), 32'(prev_d));
            if (exp_q.size() > 0) begin
                mon_t = exp_q[0];
                mon_k = cyc - mon_t.grant_cyc;
                mon_g = '0;
                if (mon_k == 1 && int'(mon_t.addr) < DEPTH) mon_g[mon_t.addr] = 1'b1;
                check("lat_g", 32'(lat_g), 32'(mon_g));
                check("lat_d", 32'(lat_d), 32'(mon_t.data));
                check("ack0", 32'(bus.ack0), 32'(mon_k == 2 && mon_t.who == 0));
                check("ack1", 32'(bus.ack1), 32'(mon_k == 2 && mon_t.who == 1));
                check("err", 32'(bus.err), 32'(mon_k == 2 && int'(mon_t.addr) >= DEPTH));
                if (mon_k >= 2) void'(exp_q.pop_front());
            end else begin
                check("lat_g_idle", 32'(lat_g), 32'd0);
                check("ack_idle", 32'({bus.ack0, bus.ack1, bus.err}), 32'd0);
            end
        end
        prev_d = lat_d;
        prev_g = lat_g;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ack(input int who, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget && n < 0; i++) begin
            @(negedge clk);
            if ((who == 0 && bus.ack0) || (who == 1 && bus.ack1)) n = i;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((bus.req0 || bus.req1 || exp_q.size() != 0 || bus.busy) && c < 60) begin
            @(negedge clk);
            c++;
            if (bus.ack0) bus.req0 = 1'b0;
            if (bus.ack1) bus.req1 = 1'b0;
        end
        check("drain_idle", 32'(c < 60), 32'd1);
    endtask

    task automatic random_traffic(input int ncyc);
        bit pend0, pend1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            pend0 = (exp_q.size() > 0) && (exp_q[0].who == 0);
            pend1 = (exp_q.size() > 0) && (exp_q[0].who == 1);
            if (bus.ack0) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.addr0 = ADDR_W'($urandom_range(0, DEPTH - 1));
                    bus.data0 = WIDTH'($urandom);
                    bus.req0  = 1'b1;
                end else bus.req0 = 1'b0;
            end else if (!bus.req0 && !pend0) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.addr0 = ADDR_W'($urandom_range(0, DEPTH - 1));
                    bus.data0 = WIDTH'($urandom);
                    bus.req0  = 1'b1;
                end
            end else if (bus.req0 && pend0 && $urandom_range(0, 3) == 0) begin
                bus.req0 = 1'b0;
            end
            if (bus.ack1) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.addr1 = ADDR_W'($urandom_range(0, DEPTH - 1));
                    bus.data1 = WIDTH'($urandom);
                    bus.req1  = 1'b1;
                end else bus.req1 = 1'b0;
            end else if (!bus.req1 && !pend1) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.addr1 = ADDR_W'($urandom_range(0, DEPTH - 1));
                    bus.data1 = WIDTH'($urandom);
                    bus.req1  = 1'b1;
                end
            end else if (bus.req1 && pend1 && $urandom_range(0, 3) == 0) begin
                bus.req1 = 1'b0;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    int n, n0, n1, got, found, n_ack, gate_seen;
    int exp_order[4];

    initial begin
        bus.req0 = 1'b0;  bus.req1 = 1'b0;
        bus.addr0 = '0;   bus.addr1 = '0;
        bus.data0 = '0;   bus.data1 = '0;
        bus3.req0 = 1'b0; bus3.req1 = 1'b0;
        bus3.addr0 = '0;  bus3.addr1 = '0;
        bus3.data0 = '0;  bus3.data1 = '0;
`ifdef LBC_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_lat_g", 32'(lat_g), 32'd0);
        check("rst_lat_d", 32'(lat_d), 32'd0);
        check("rst_ack0", 32'(bus.ack0), 32'd0);
        check("rst_ack1", 32'(bus.ack1), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        #2 rst_n = 1'b1;

        // Single write: addr 2, 0xA5
        @(negedge clk);
        bus.addr0 = 2'd2; bus.data0 = 8'hA5; bus.req0 = 1'b1;
        wait_ack(0, 8, n);
        bus.req0 = 1'b0;
        check("single_ack_latency", 32'(n), 32'd3);
        @(negedge clk);
        check("single_busy_done", 32'(bus.busy), 32'd0);

        // Out-of-range address on the DEPTH=3 instance
        bus3.addr1 = 2'd3; bus3.data1 = 8'h5A; bus3.req1 = 1'b1;
        gate_seen = 0;
        n = -1;
        for (int c = 1; c <= 8 && n < 0; c++) begin
            @(negedge clk);
            if (lat_g3 != '0) gate_seen = 1;
            if (bus3.ack1) begin
                n = c;
                check("oor_err", 32'(bus3.err), 32'd1);
                check("oor_ack0_quiet", 32'(bus3.ack0), 32'd0);
                check("oor_busy", 32'(bus3.busy), 32'd1);
                check("oor_lat_d", 32'(lat_d3), 32'h5A);
            end
        end
        bus3.req1 = 1'b0;
        check("oor_gate_closed", 32'(gate_seen), 32'd0);
        check("oor_ack_latency", 32'(n), 32'd3);

        // Simultaneous requests from a fresh reset, dropped on ack
        pulse_reset();
        @(negedge clk);
        bus.addr0 = 2'd0; bus.data0 = 8'h11;
        bus.addr1 = 2'd1; bus.data1 = 8'h22;
        bus.req0 = 1'b1;  bus.req1 = 1'b1;
        wait_ack(0, 8, n0);
        bus.req0 = 1'b0;
        check("tie_first_ack0", 32'(n0), 32'd3);
        wait_ack(1, 8, n1);
        bus.req1 = 1'b0;
        check("tie_second_gap", 32'(n1), 32'd4);

        // Both held through acks: arbitration order over four writes
        @(negedge clk);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = -1;
            for (int c = 0; c < 8 && got < 0; c++) begin
                @(negedge clk);
                if (bus.ack0)      got = 0;
                else if (bus.ack1) got = 1;
            end
            check("arb_order", 32'(got), 32'(exp_order[k]));
            if (k == 3) begin
                if (got == 0) bus.req0 = 1'b0;
                if (got == 1) bus.req1 = 1'b0;
            end
        end
        drain();

        // Request dropped right after grant still completes
        @(negedge clk);
        bus.addr0 = 2'd3; bus.data0 = 8'hC3; bus.req0 = 1'b1;
        @(negedge clk);
        check("drop_granted_busy", 32'(bus.busy), 32'd1);
        bus.req0 = 1'b0;
        wait_ack(0, 6, n);
        check("drop_ack_latency", 32'(n), 32'd2);
        drain();

        // Reset while the gate is open
        @(negedge clk);
        bus.addr0 = 2'd0; bus.data0 = 8'h3C; bus.req0 = 1'b1;
        found = 0;
        for (int c = 0; c < 8 && found == 0; c++) begin
            @(negedge clk);
            if (lat_g == 4'b0001) found = 1;
        end
        check("open_reached", 32'(found), 32'd1);
        bus.req0 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_open_lat_g", 32'(lat_g), 32'd0);
        check("rst_open_lat_d", 32'(lat_d), 32'd0);
        check("rst_open_busy", 32'(bus.busy), 32'd0);
        check("rst_open_ack0", 32'(bus.ack0), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        n_ack = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) n_ack++;
        end
        check("rst_open_no_ack", 32'(n_ack), 32'd0);

        // Random traffic, protocol and scoreboard checks run in the monitor
        random_traffic(600);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
